// File: rtl/network_readback_tx.sv
// network_readback_tx
//   Byte-serial readback transmitter for the perceptron network. On a start
//   request it snapshots the neuron outputs and, optionally, every parameter
//   byte, then sends them as a framed stream over a valid/ack byte port:
//     HEADER, LEN, payload[0..LEN-1], CKSUM (mod-256 sum of payload only).
//   Payload order: neuron outputs 0..NUM_NEURONS-1, then (mode 1) parameter
//   bytes k = 0..NUM_NEURONS*PARAMS_PER_NEURON-1.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous active-high reset
//   start            frame request, sampled only in IDLE
//   mode             0 = neuron outputs only, 1 = outputs plus parameters
//   abort            synchronous frame abort (wins over tx_ack)
//   neuron_out_flat  neuron j output at [8j+7:8j]
//   params_flat      parameter byte k at [8k+7:8k]
//   tx_data          current frame byte (0 when idle)
//   tx_valid         tx_data is valid
//   tx_ack           host accepts tx_data (ignored while tx_valid = 0)
//   busy             high whenever a frame is in progress
//   done             one-cycle pulse after the checksum byte is accepted
module network_readback_tx #(
  parameter int          NUM_NEURONS       = 4,
  parameter int          PARAMS_PER_NEURON = 6,
  parameter logic [7:0]  HEADER            = 8'hA5
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic                                      mode,
  input  logic                                      abort,
  input  logic [8*NUM_NEURONS-1:0]                  neuron_out_flat,
  input  logic [8*NUM_NEURONS*PARAMS_PER_NEURON-1:0] params_flat,
  output logic [7:0]                                tx_data,
  output logic                                      tx_valid,
  input  logic                                      tx_ack,
  output logic                                      busy,
  output logic                                      done
);

  localparam int NUM_PARAMS    = NUM_NEURONS * PARAMS_PER_NEURON;
  localparam int PAYLOAD_BYTES = NUM_NEURONS + NUM_PARAMS;

  localparam logic [4:0] LEN_SHORT = 5'(NUM_NEURONS);
  localparam logic [4:0] LEN_LONG  = 5'(PAYLOAD_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LEN,
    PAYLOAD,
    CKSUM
  } state_t;

  state_t                     state;
  state_t                     state_nx;
  logic                       done_nx;

  // Neuron bytes sit below parameter bytes so that payload byte i is simply
  // snapshot byte i, whichever mode is active.
  logic [8*PAYLOAD_BYTES-1:0] snap;
  logic                       mode_r;
  logic [4:0]                 idx;
  logic [7:0]                 cksum;

  logic [4:0]                 len;
  logic [7:0]                 payload_byte;
  logic                       xfer;
  logic                       load;
  logic                       clear;
  logic                       step;
  logic                       last;

  function automatic logic [7:0] add_mod256(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  assign len          = mode_r ? LEN_LONG : LEN_SHORT;
  assign payload_byte = snap[{idx, 3'b000} +: 8];
  assign tx_valid     = (state != IDLE);
  assign busy         = (state != IDLE);
  assign xfer         = tx_valid && tx_ack && !abort;
  assign last         = (idx == len - 5'd1);

  assign load  = (state == IDLE) && start && !abort;
  assign clear = (state == LEN) && xfer;
  assign step  = (state == PAYLOAD) && xfer;

  always_comb begin
    tx_data = 8'h00;
    case (state)
      HDR:     tx_data = HEADER;
      LEN:     tx_data = {3'b000, len};
      PAYLOAD: tx_data = payload_byte;
      CKSUM:   tx_data = cksum;
      default: tx_data = 8'h00;
    endcase
  end

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      IDLE:    if (load) state_nx = HDR;
      HDR:     if (xfer) state_nx = LEN;
      LEN:     if (xfer) state_nx = PAYLOAD;
      PAYLOAD: if (xfer && last) state_nx = CKSUM;
      CKSUM: begin
        if (xfer) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // abort drops the frame from any active state without a done pulse
    if (abort && state != IDLE) begin
      state_nx = IDLE;
      done_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap   <= '0;
      mode_r <= 1'b0;
      idx    <= 5'd0;
      cksum  <= 8'h00;
    end else begin
      if (load) begin
        snap   <= {params_flat, neuron_out_flat};
        mode_r <= mode;
      end
      if (clear) begin
        idx   <= 5'd0;
        cksum <= 8'h00;
      end else if (step) begin
        idx   <= idx + 5'd1;
        cksum <= add_mod256(cksum, payload_byte);
      end
    end
  end

endmodule

// File: tb/tb_network_readback_tx.sv
module tb_network_readback_tx;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         mode;
  logic         abort;
  logic [31:0]  neuron_out_flat;
  logic [191:0] params_flat;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ack;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [7:0] cap[$];
  logic [7:0] exp_q[$];

  logic       prev_valid = 1'b0;
  logic       prev_ack = 1'b0;
  logic [7:0] prev_data = 8'h00;

  network_readback_tx dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .mode            (mode),
    .abort           (abort),
    .neuron_out_flat (neuron_out_flat),
    .params_flat     (params_flat),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ack          (tx_ack),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; the monitor samples
  // on the falling edge, well away from both.
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_valid && !prev_ack && tx_valid)
        chk("hold", {24'h0, tx_data}, {24'h0, prev_data});
      if (tx_valid && tx_ack && !abort)
        cap.push_back(tx_data);
      if (done)
        done_cnt++;
    end
    prev_valid = tx_valid && !reset;
    prev_ack   = tx_ack || abort;
    prev_data  = tx_data;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_exp_m0();
    exp_q = {};
    exp_q.push_back(8'hA5); exp_q.push_back(8'h04);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    exp_q.push_back(8'h03); exp_q.push_back(8'h04);
    exp_q.push_back(8'h0A);
  endtask

  task automatic set_exp_m1_ff();
    exp_q = {};
    exp_q.push_back(8'hA5); exp_q.push_back(8'h1C);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
    for (int i = 0; i < 24; i++) exp_q.push_back(8'hFF);
    exp_q.push_back(8'hE8);
  endtask

  task automatic cmp_frame(input string tag);
    chk({tag, "_len"}, cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), {24'h0, cap[i]}, {24'h0, exp_q[i]});
  endtask

  // Issue start for one edge; afterwards the header must be on the port.
  task automatic do_start(input logic m, input string tag);
    cap   = {};
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_hdr"}, {24'h0, tx_data}, 32'hA5);
    chk({tag, "_vld"}, {31'h0, tx_valid}, 32'h1);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h1);
  endtask

  // Runs until done is seen (leaves the bench inside the done cycle).
  task automatic run_frame(input int ackper, output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin
      tx_ack = (ackper <= 1) ? 1'b1 : ((cyc % ackper) == (ackper - 1));
      tick();
      cyc++;
    end
    tx_ack = 1'b1;
    if (!done) chk("done_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    int cyc;
    int dc;
    reset = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; tx_ack = 1'b0;
    neuron_out_flat = 32'h0; params_flat = '0;
    tick(); tick();
    chk("rst_data", {24'h0, tx_data}, 32'h0);
    chk("rst_vld", {31'h0, tx_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    reset = 1'b0;
    tick();

    // abort together with start in IDLE: start ignored
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle", {31'h0, busy}, 32'h0);

    // 1: mode 0, ack held high
    neuron_out_flat = 32'h04030201;
    tx_ack = 1'b1;
    do_start(1'b0, "t1");
    run_frame(1, cyc);
    chk("t1_cycles", cyc, 7);
    chk("t1_busy_end", {31'h0, busy}, 32'h0);
    chk("t1_vld_end", {31'h0, tx_valid}, 32'h0);
    chk("t1_data_end", {24'h0, tx_data}, 32'h0);
    tick();
    chk("t1_done_1cyc", {31'h0, done}, 32'h0);
    chk("t1_done_cnt", done_cnt, 1);
    set_exp_m0();
    cmp_frame("t1");

    // 2: mode 1, neurons 00, params all FF
    neuron_out_flat = 32'h0;
    params_flat = {192{1'b1}};
    do_start(1'b1, "t2");
    run_frame(1, cyc);
    chk("t2_cycles", cyc, 31);
    tick();
    set_exp_m1_ff();
    cmp_frame("t2");
    chk("t2_done_cnt", done_cnt, 2);

    // 3: mode 0, ack 1 cycle in 3
    neuron_out_flat = 32'h04030201;
    tx_ack = 1'b0;
    do_start(1'b0, "t3");
    run_frame(3, cyc);
    chk("t3_cycles", cyc, 21);
    tick();
    set_exp_m0();
    cmp_frame("t3");

    // 4: input bus changes after the header do not affect the frame
    do_start(1'b0, "t4");
    tx_ack = 1'b1;
    tick();
    neuron_out_flat = 32'h55555555;
    run_frame(1, cyc);
    tick();
    cmp_frame("t4");
    neuron_out_flat = 32'h04030201;

    // 5: abort while payload byte 2 is presented
    dc = done_cnt;
    do_start(1'b0, "t5");
    for (int i = 0; i < 4; i++) tick();
    chk("t5_pl2", {24'h0, tx_data}, 32'h03);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_vld", {31'h0, tx_valid}, 32'h0);
    chk("t5_busy", {31'h0, busy}, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    chk("t5_no_done", done_cnt, dc);
    chk("t5_cap_len", cap.size(), 4);
    do_start(1'b0, "t5b");
    run_frame(1, cyc);
    tick();
    cmp_frame("t5b");

    // 6: asynchronous reset mid-frame
    dc = done_cnt;
    do_start(1'b0, "t6");
    tick(); tick();
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_data", {24'h0, tx_data}, 32'h0);
    chk("t6_rst_vld", {31'h0, tx_valid}, 32'h0);
    chk("t6_rst_busy", {31'h0, busy}, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("t6_no_done", done_cnt, dc);
    chk("t6_idle", {31'h0, busy}, 32'h0);

    // start while busy is ignored (including the mode request)
    do_start(1'b0, "t6b");
    tick();
    mode = 1'b1; start = 1'b1;
    tick();
    mode = 1'b0; start = 1'b0;
    run_frame(1, cyc);
    set_exp_m0();
    cmp_frame("t6b");
    // start in the done cycle begins a new frame
    chk("t6_done_now", {31'h0, done}, 32'h1);
    do_start(1'b0, "t6c");
    run_frame(1, cyc);
    tick();
    cmp_frame("t6c");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
